// File: rtl/lk_gradient_window.sv
// Collects a 3x3 current/previous pixel patch and produces the Lucas-Kanade
// A matrix (Ix, Iy per anchor) and b vector (-It per anchor) for the 2x2 anchors.
//
// Handshakes: a beat transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. The source
// holds its beat while in_ready is low, and A/b stay stable while out_valid is
// high until that transfer.
module lk_gradient_window #(
   parameter int PIX_W = 8,
   parameter int OUT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_last,
   input  logic [PIX_W-1:0]     pix_curr,
   input  logic [PIX_W-1:0]     pix_prev,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*OUT_W-1:0]   A,
   output logic [4*OUT_W-1:0]   b,
   output logic                 pkt_err
);

   typedef enum logic [1:0] {
      S_LOAD    = 2'd0,
      S_COMPUTE = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   state_t               state, state_next;
   logic [3:0]           count;
   logic                 beat_acc;
   logic                 frame_err;
   logic [PIX_W-1:0]     curr_q [8];
   logic [PIX_W-1:0]     prev_q [4];
   logic [8*OUT_W-1:0]   a_next;
   logic [4*OUT_W-1:0]   b_next;

   // Halved difference with floor rounding, taken at PIX_W+1 signed bits.
   function automatic logic [OUT_W-1:0] half_diff(input logic [PIX_W-1:0] p,
                                                   input logic [PIX_W-1:0] q);
      logic signed [PIX_W:0] d;
      d = $signed({1'b0, p}) - $signed({1'b0, q});
      return OUT_W'(d >>> 1);
   endfunction

   function automatic logic [OUT_W-1:0] neg_sat(input logic [OUT_W-1:0] v);
      logic [OUT_W-1:0] min_v;
      min_v = {1'b1, {(OUT_W-1){1'b0}}};
      if (v == min_v) return {1'b0, {(OUT_W-1){1'b1}}};
      return -v;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= S_LOAD;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      beat_acc   = 1'b0;
      frame_err  = 1'b0;
      case (state)
         S_LOAD: begin
            in_ready = 1'b1;
            beat_acc = in_valid;
            if (in_valid) begin
               if (in_last && count == 4'd8) state_next = S_COMPUTE;
               else if (in_last || count == 4'd8) frame_err = 1'b1;
            end
         end
         S_COMPUTE: state_next = S_HOLD;
         S_HOLD: begin
            if (out_valid && out_ready) state_next = S_LOAD;
         end
         default: state_next = S_LOAD;
      endcase
   end

   // A framed or misframed final beat both restart the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= 4'd0;
         out_valid <= 1'b0;
         pkt_err   <= 1'b0;
         A         <= '0;
         b         <= '0;
      end else begin
         pkt_err <= frame_err;
         if (beat_acc) count <= (in_last || count == 4'd8) ? 4'd0 : count + 4'd1;
         if (state == S_COMPUTE) begin
            A <= a_next;
            b <= b_next;
         end
         if (state == S_HOLD) out_valid <= !(out_valid && out_ready);
         else                 out_valid <= 1'b0;
      end
   end

   // Only pixels that feed an anchor or its neighbours are kept.
   always_ff @(posedge clk) begin
      if (beat_acc) begin
         for (int j = 0; j < 8; j++) begin
            if (count == 4'(j)) curr_q[j] <= pix_curr;
         end
         case (count)
            4'd0:    prev_q[0] <= pix_prev;
            4'd1:    prev_q[1] <= pix_prev;
            4'd3:    prev_q[2] <= pix_prev;
            4'd4:    prev_q[3] <= pix_prev;
            default: ;
         endcase
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_anchor
      localparam int K = (i / 2) * 3 + (i % 2);
      assign a_next[8*OUT_W-1-2*OUT_W*i -: OUT_W]       = half_diff(curr_q[K+1], curr_q[K]);
      assign a_next[8*OUT_W-1-2*OUT_W*i-OUT_W -: OUT_W] = half_diff(curr_q[K+3], curr_q[K]);
      assign b_next[4*OUT_W-1-OUT_W*i -: OUT_W]         = neg_sat(half_diff(curr_q[K], prev_q[i]));
   end

endmodule

// File: tb/tb_lk_gradient_window.sv
// Directed and randomized patches for lk_gradient_window, checked against an
// arithmetic model of the gradient rules.
module tb_lk_gradient_window;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_last;
   logic [7:0]  pix_curr;
   logic [7:0]  pix_prev;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] A;
   logic [31:0] b;
   logic        pkt_err;

   int n_vec = 0;
   int n_err = 0;
   int cur_px [3][3];
   int prv_px [3][3];

   always #5 clk = ~clk;

   lk_gradient_window #(.PIX_W(8), .OUT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .pix_curr  (pix_curr),
      .pix_prev  (pix_prev),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .A         (A),
      .b         (b),
      .pkt_err   (pkt_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int half_floor(input int x);
      return (x >= 0) ? x / 2 : -((1 - x) / 2);
   endfunction

   // Reference: gradients straight from the pixel grid, packed anchor 0 first.
   task automatic model(output logic [63:0] ea, output logic [31:0] eb);
      int ix, iy, it, bi;
      ea = '0;
      eb = '0;
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 2; c++) begin
            ix = half_floor(cur_px[r][c+1] - cur_px[r][c]);
            iy = half_floor(cur_px[r+1][c] - cur_px[r][c]);
            it = half_floor(cur_px[r][c] - prv_px[r][c]);
            bi = -it;
            if (bi > 127) bi = 127;
            ea = (ea << 16) | {48'd0, 8'(ix), 8'(iy)};
            eb = (eb << 8) | {24'd0, 8'(bi)};
         end
      end
   endtask

   task automatic fill(input int mode);
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            case (mode)
               0: begin cur_px[r][c] = 100; prv_px[r][c] = 100; end
               1: begin cur_px[r][c] = 20 + 40*r + 10*c; prv_px[r][c] = cur_px[r][c] - 4; end
               2: begin cur_px[r][c] = 0; prv_px[r][c] = 0; end
               default: begin
                  cur_px[r][c] = ($urandom_range(0, 3) == 0) ? 255 * $urandom_range(0, 1)
                                                              : $urandom_range(0, 255);
                  prv_px[r][c] = ($urandom_range(0, 3) == 0) ? 255 * $urandom_range(0, 1)
                                                              : $urandom_range(0, 255);
               end
            endcase
         end
      end
   endtask

   task automatic send_beats(input string tag, input int n, input int last_at);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      for (int k = 0; k < n; k++) begin
         in_valid = 1'b1;
         pix_curr = 8'(cur_px[k/3][k%3]);
         pix_prev = 8'(prv_px[k/3][k%3]);
         in_last  = (k == last_at);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Called #1 after the edge that took the final beat (edge T).
   task automatic expect_result(input string tag, input int stall, input bit hold_beat,
                                input bit use_const, input logic [63:0] ca, input logic [31:0] cb);
      logic [63:0] ea;
      logic [31:0] eb;
      model(ea, eb);
      check({tag, "_ov_t0"}, 64'(out_valid), 64'd0);
      check({tag, "_err_t0"}, 64'(pkt_err), 64'd0);
      tick();
      check({tag, "_ov_t1"}, 64'(out_valid), 64'd0);
      tick();
      check({tag, "_ov_t2"}, 64'(out_valid), 64'd1);
      check({tag, "_A"}, A, ea);
      check({tag, "_b"}, 64'(b), 64'(eb));
      check({tag, "_ird_hold"}, 64'(in_ready), 64'd0);
      if (use_const) begin
         check({tag, "_A_const"}, A, ca);
         check({tag, "_b_const"}, 64'(b), 64'(cb));
      end
      if (hold_beat) begin
         in_valid = 1'b1;
         in_last  = 1'b1;
         pix_curr = 8'hFF;
         pix_prev = 8'h00;
      end
      for (int s = 0; s < stall; s++) begin
         tick();
         check({tag, "_ov_stall"}, 64'(out_valid), 64'd1);
         check({tag, "_A_stall"}, A, ea);
         check({tag, "_b_stall"}, 64'(b), 64'(eb));
         check({tag, "_ird_stall"}, 64'(in_ready), 64'd0);
         check({tag, "_err_stall"}, 64'(pkt_err), 64'd0);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_ov_done"}, 64'(out_valid), 64'd0);
      check({tag, "_ird_done"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      pix_curr  = 8'd0;
      pix_prev  = 8'd0;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_A", A, 64'd0);
      check("rst_b", 64'(b), 64'd0);
      check("rst_pkt_err", 64'(pkt_err), 64'd0);

      fill(0);
      send_beats("flat", 9, 8);
      expect_result("flat", 0, 1'b0, 1'b1, 64'h0, 32'h0);

      fill(1);
      send_beats("ramp", 9, 8);
      expect_result("ramp", 0, 1'b0, 1'b1, 64'h0514_0514_0514_0514, 32'hFEFE_FEFE);

      fill(2);
      cur_px[0][0] = 255;
      send_beats("ext_min", 9, 8);
      expect_result("ext_min", 0, 1'b0, 1'b1, 64'h8080_0000_0000_0000, 32'h8100_0000);

      fill(2);
      prv_px[0][0] = 255;
      send_beats("ext_sat", 9, 8);
      expect_result("ext_sat", 0, 1'b0, 1'b1, 64'h0, 32'h7F00_0000);

      // Early in_last on beat 4.
      fill(0);
      send_beats("early", 5, 4);
      check("early_pkt_err", 64'(pkt_err), 64'd1);
      tick();
      check("early_pkt_err_drop", 64'(pkt_err), 64'd0);
      for (int s = 0; s < 3; s++) begin
         tick();
         check("early_no_ov", 64'(out_valid), 64'd0);
      end
      send_beats("after_early", 9, 8);
      expect_result("after_early", 0, 1'b0, 1'b1, 64'h0, 32'h0);

      // in_last missing on beat 8.
      fill(1);
      send_beats("nolast", 9, -1);
      check("nolast_pkt_err", 64'(pkt_err), 64'd1);
      tick();
      check("nolast_pkt_err_drop", 64'(pkt_err), 64'd0);
      check("nolast_no_ov", 64'(out_valid), 64'd0);

      // Backpressure with a pending beat that must not be consumed.
      fill(1);
      send_beats("bp", 9, 8);
      expect_result("bp", 5, 1'b1, 1'b1, 64'h0514_0514_0514_0514, 32'hFEFE_FEFE);
      fill(0);
      send_beats("after_bp", 9, 8);
      expect_result("after_bp", 0, 1'b0, 1'b1, 64'h0, 32'h0);

      // Reset after six beats of a partial patch.
      fill(3);
      send_beats("midrst", 6, -1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_A", A, 64'd0);
      check("midrst_b", 64'(b), 64'd0);
      fill(1);
      send_beats("midrst_ramp", 9, 8);
      expect_result("midrst_ramp", 0, 1'b0, 1'b1, 64'h0514_0514_0514_0514, 32'hFEFE_FEFE);

      for (int n = 0; n < 30; n++) begin
         fill(3);
         send_beats("rand", 9, 8);
         expect_result("rand", $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 64'h0, 32'h0);
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
